// File: rtl/iicc_sync_servo_if.sv
// rtl/iicc_sync_servo_if.sv - offset sample in / counter correction out bundle for the sync servo
interface iicc_sync_servo_if #(
  parameter int TDW  = 65,
  parameter int CW   = 52,
  parameter int FRAC = 12
);
  logic                   tdiff_stb;
  logic signed [TDW-1:0]  tdiff;
  logic        [CW-1:0]   corr;
  logic        [FRAC-1:0] corr_frac;
  logic                   corr_stb;

  modport master (output tdiff_stb, tdiff, input corr, corr_frac, corr_stb);
  modport slave  (input tdiff_stb, tdiff, output corr, corr_frac, corr_stb);
endinterface

// File: rtl/iicc_sync_servo.sv
// rtl/iicc_sync_servo.sv - outlier-rejecting step/PI servo producing the txusrclk counter correction
module iicc_sync_servo #(
  parameter int TDW         = 65,
  parameter int CW          = 52,
  parameter int FRAC        = 12,
  parameter int EW          = 32,
  parameter int KP_SHIFT    = 2,
  parameter int KI_SHIFT    = 6,
  parameter int STEP_TH     = 4096,
  parameter int LOCK_TH     = 64,
  parameter int LOCK_CNT    = 8,
  parameter int OUTLIER_MAX = 3,
  parameter int INT_LIM     = 65535
) (
  input  logic                  txusrclk,
  input  logic                  rstn,
  input  logic                  enable,
  iicc_sync_servo_if.slave      link,
  output logic [1:0]            state,
  output logic                  locked,
  output logic [7:0]            overrun
);

  localparam int AW = CW + FRAC;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(OUTLIER_MAX + 1);

  localparam logic signed [EW-1:0]  E_MAX   = {1'b0, {(EW-1){1'b1}}};
  localparam logic signed [EW-1:0]  E_MIN   = {1'b1, {(EW-1){1'b0}}};
  localparam logic signed [TDW-1:0] HALF_HI = {{(TDW-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [TDW-1:0] HALF_LO = {{(TDW-EW+1){1'b1}}, {(EW-1){1'b0}}};
  localparam logic signed [EW:0]    ILIM_P  = (EW+1)'(INT_LIM);
  localparam logic signed [EW:0]    ILIM_N  = -ILIM_P;

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} state_t;

  state_t                st, st_n;
  logic [AW-1:0]         acc, acc_n;
  logic signed [EW-1:0]  integ, integ_n;
  logic [GW-1:0]         good, good_n;
  logic [RW-1:0]         rej, rej_n;
  logic                  stb_q;

  logic                  s1_v, s2_v;
  logic signed [EW-1:0]  s1_e, s2_e, s2_integ;
  logic                  s2_big, s2_win;

  function automatic logic [AW-1:0] sext(input logic [EW-1:0] v);
    return {{(AW-EW){v[EW-1]}}, v};
  endfunction

  // Stage 1 input: halve the round-trip sum and clamp into the error width.
  logic signed [TDW-1:0] half;
  logic signed [EW-1:0]  e_in;
  logic                  busy, accept;

  assign half   = link.tdiff >>> 1;
  assign busy   = s1_v || s2_v;
  assign accept = enable && link.tdiff_stb && !busy;

  always_comb begin
    if (half > HALF_HI)      e_in = E_MAX;
    else if (half < HALF_LO) e_in = E_MIN;
    else                     e_in = half[EW-1:0];
  end

  // Stage 2 input: magnitude, threshold decisions and saturating integrator candidate.
  logic [EW-1:0]        ae;
  logic signed [EW-1:0] ki, integ_c;
  logic signed [EW:0]   isum;

  assign ki   = s1_e >>> KI_SHIFT;
  assign isum = $signed({integ[EW-1], integ}) + $signed({ki[EW-1], ki});

  always_comb begin
    if (s1_e == E_MIN)     ae = E_MAX;
    else if (s1_e < 0)     ae = -s1_e;
    else                   ae = s1_e;
    if (isum > ILIM_P)      integ_c = ILIM_P[EW-1:0];
    else if (isum < ILIM_N) integ_c = ILIM_N[EW-1:0];
    else                    integ_c = isum[EW-1:0];
  end

  // Stage 3 input: servo state machine and accumulator update.
  logic signed [EW-1:0] kp;
  logic [AW-1:0]        acc_step, acc_pi;

  assign kp       = s2_e >>> KP_SHIFT;
  assign acc_step = acc + sext(s2_e);
  assign acc_pi   = acc + sext(kp) + sext(s2_integ);

  always_comb begin
    st_n    = st;
    acc_n   = acc;
    integ_n = integ;
    good_n  = good;
    rej_n   = rej;
    case (st)
      IDLE: begin
        acc_n   = acc_step;
        integ_n = '0;
        good_n  = '0;
        rej_n   = '0;
        st_n    = ACQ;
      end
      ACQ: begin
        if (s2_big) begin
          acc_n   = acc_step;
          integ_n = '0;
          good_n  = '0;
        end else begin
          acc_n   = acc_pi;
          integ_n = s2_integ;
          good_n  = s2_win ? good + 1'b1 : '0;
          if (good_n == GW'(LOCK_CNT)) begin
            st_n  = LOCKED;
            rej_n = '0;
          end
        end
      end
      LOCKED: begin
        if (s2_big) begin
          rej_n = rej + 1'b1;
          if (rej_n == RW'(OUTLIER_MAX)) begin
            st_n   = ACQ;
            good_n = '0;
            rej_n  = '0;
          end
        end else begin
          acc_n   = acc_pi;
          integ_n = s2_integ;
          rej_n   = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge txusrclk or negedge rstn) begin
    if (!rstn) begin
      st       <= IDLE;
      acc      <= '0;
      integ    <= '0;
      good     <= '0;
      rej      <= '0;
      stb_q    <= 1'b0;
      locked   <= 1'b0;
      overrun  <= '0;
      s1_v     <= 1'b0;
      s1_e     <= '0;
      s2_v     <= 1'b0;
      s2_e     <= '0;
      s2_integ <= '0;
      s2_big   <= 1'b0;
      s2_win   <= 1'b0;
    end else if (!enable) begin
      // acc is held so the link keeps its last correction while the servo is parked.
      st     <= IDLE;
      integ  <= '0;
      good   <= '0;
      rej    <= '0;
      stb_q  <= 1'b0;
      locked <= 1'b0;
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) s1_e <= e_in;
      s2_v <= s1_v;
      if (s1_v) begin
        s2_e     <= s1_e;
        s2_integ <= integ_c;
        s2_big   <= ae > EW'(STEP_TH);
        s2_win   <= ae <= EW'(LOCK_TH);
      end
      stb_q <= s2_v;
      if (s2_v) begin
        st     <= st_n;
        acc    <= acc_n;
        integ  <= integ_n;
        good   <= good_n;
        rej    <= rej_n;
        locked <= (st_n == LOCKED);
      end
      if (link.tdiff_stb && busy && overrun != 8'hFF) overrun <= overrun + 8'd1;
    end
  end

  assign link.corr      = acc[AW-1:FRAC];
  assign link.corr_frac = acc[FRAC-1:0];
  assign link.corr_stb  = stb_q;
  assign state          = st;

endmodule

// File: tb/tb_iicc_sync_servo.sv
// tb/tb_iicc_sync_servo.sv - directed self-checking bench for iicc_sync_servo
module tb_iicc_sync_servo;

  logic       clk;
  logic       rstn;
  logic       enable;
  logic [1:0] state;
  logic       locked;
  logic [7:0] overrun;
  int         n_chk;
  int         n_err;

  iicc_sync_servo_if bus ();

  iicc_sync_servo dut (
    .txusrclk (clk),
    .rstn     (rstn),
    .enable   (enable),
    .link     (bus.slave),
    .state    (state),
    .locked   (locked),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where corr_stb must be high.
  task automatic send(input logic [64:0] v);
    bus.tdiff_stb = 1'b1;
    bus.tdiff     = v;
    @(negedge clk);
    bus.tdiff_stb = 1'b0;
    @(negedge clk);
    check("stb_early", bus.corr_stb, 0);
    @(negedge clk);
    check("stb", bus.corr_stb, 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rstn = 1'b0;
    enable = 1'b0;
    bus.tdiff_stb = 1'b0;
    bus.tdiff = '0;
    repeat (3) @(negedge clk);
    check("rst_corr", bus.corr, 0);
    check("rst_frac", bus.corr_frac, 0);
    check("rst_stb", bus.corr_stb, 0);
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_overrun", overrun, 0);
    rstn = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    send(65'sd81920);
    check("step_corr", bus.corr, 10);
    check("step_frac", bus.corr_frac, 0);
    check("step_state", state, 1);
    send(65'sd200);
    check("pi_corr", bus.corr, 10);
    check("pi_frac", bus.corr_frac, 26);

    repeat (7) send(65'sd0);
    send(65'sd200);
    check("nolock_state", state, 1);
    check("nolock_frac", bus.corr_frac, 60);

    for (int i = 0; i < 8; i++) begin
      send(65'sd0);
      if (i == 6) check("lock_7th", locked, 0);
    end
    check("lock_8th", locked, 1);
    check("lock_state", state, 2);
    check("lock_frac", bus.corr_frac, 76);

    for (int i = 0; i < 2; i++) begin
      send(65'sd16386);
      check("out2_frac", bus.corr_frac, 76);
      check("out2_state", state, 2);
    end
    send(65'sd0);
    check("out2_keep", state, 2);
    check("out2_pi", bus.corr_frac, 78);

    for (int i = 0; i < 3; i++) begin
      send(65'sd16386);
      check("out3_corr", bus.corr, 10);
      check("out3_frac", bus.corr_frac, 78);
      check("out3_state", state, (i < 2) ? 2 : 1);
    end

    bus.tdiff_stb = 1'b1;
    bus.tdiff = 65'sd0;
    @(negedge clk);
    bus.tdiff = 65'sd81920;
    @(negedge clk);
    bus.tdiff_stb = 1'b0;
    check("ovr_early", bus.corr_stb, 0);
    @(negedge clk);
    check("ovr_stb", bus.corr_stb, 1);
    check("ovr_count", overrun, 1);
    check("ovr_frac", bus.corr_frac, 80);
    @(negedge clk);
    check("ovr_single", bus.corr_stb, 0);
    check("ovr_corr", bus.corr, 10);

    bus.tdiff_stb = 1'b1;
    bus.tdiff = 65'sd81920;
    @(negedge clk);
    bus.tdiff_stb = 1'b0;
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("dis_nostb", bus.corr_stb, 0);
    end
    check("dis_state", state, 0);
    check("dis_locked", locked, 0);
    check("dis_corr", bus.corr, 10);
    check("dis_frac", bus.corr_frac, 80);
    bus.tdiff_stb = 1'b1;
    @(negedge clk);
    bus.tdiff_stb = 1'b0;
    @(negedge clk);
    check("dis_ignore", overrun, 1);
    enable = 1'b1;
    @(negedge clk);
    send(65'sd0);
    check("reen_state", state, 1);
    check("reen_frac", bus.corr_frac, 80);
    send(65'sd200);
    check("reen_integ", bus.corr_frac, 106);

    bus.tdiff_stb = 1'b1;
    bus.tdiff = 65'sd81920;
    @(negedge clk);
    bus.tdiff_stb = 1'b0;
    rstn = 1'b0;
    #1;
    check("arst_corr", bus.corr, 0);
    check("arst_frac", bus.corr_frac, 0);
    check("arst_state", state, 0);
    check("arst_overrun", overrun, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("arst_nostb", bus.corr_stb, 0);
    end

    send(-65'sd8192);
    check("wrap_corr", bus.corr, 64'h000F_FFFF_FFFF_FFFF);
    check("wrap_frac", bus.corr_frac, 0);
    send(65'sh0_4000_0000_0000_0000);
    check("esat_corr", bus.corr, 524286);
    check("esat_frac", bus.corr_frac, 4095);

    bus.tdiff_stb = 1'b1;
    bus.tdiff = 65'sd0;
    repeat (800) @(negedge clk);
    bus.tdiff_stb = 1'b0;
    check("ovr_sat", overrun, 255);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
